// File: rtl/seg_scan_ctrl_if.sv
// Load path and display-drive bundle of the 7-segment scan controller.
// The controller sits on the slave side; the CPU/display side uses master.
interface seg_scan_ctrl_if;
    logic        load;
    logic [11:0] bcd_in;
    logic        load_ack;
    logic [3:0]  digit_bcd;
    logic        digit_blank;
    logic [3:0]  digit_en;

    modport master (
        output load,
        output bcd_in,
        input  load_ack,
        input  digit_bcd,
        input  digit_blank,
        input  digit_en
    );

    modport slave (
        input  load,
        input  bcd_in,
        output load_ack,
        output digit_bcd,
        output digit_blank,
        output digit_en
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 4-digit 7-segment scan controller with dead-time blanking,
// leading-zero suppression and tear-free (frame-boundary) display updates.
module seg_scan_ctrl #(
    parameter int ON_CYCLES    = 2048,
    parameter int BLANK_CYCLES = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           en,
    input  logic           lzs,
    seg_scan_ctrl_if.slave bus
);
    localparam int MAXC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] ON_LAST    = CW'(ON_CYCLES - 1);

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t        state_reg, state_next;
    logic [1:0]    idx_reg, idx_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          restart_reg;
    logic [11:0]   disp_reg, disp_next;
    logic [11:0]   shadow_reg, shadow_next;
    logic          pending_reg, pending_next;
    logic [3:0]    digit_en_reg, digit_en_next;
    logic [3:0]    digit_bcd_reg, digit_bcd_next;
    logic          digit_blank_reg, digit_blank_next;
    logic          load_ack_reg, load_ack_next;
    logic          frame_edge;
    logic          load_digit;

    // State and output registers; outputs reset straight to the dark state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_BLANK;
            idx_reg         <= 2'd0;
            cnt_reg         <= '0;
            restart_reg     <= 1'b1;
            disp_reg        <= 12'h000;
            shadow_reg      <= 12'h000;
            pending_reg     <= 1'b0;
            digit_en_reg    <= 4'b0000;
            digit_bcd_reg   <= 4'h0;
            digit_blank_reg <= 1'b1;
            load_ack_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            idx_reg         <= idx_next;
            cnt_reg         <= cnt_next;
            restart_reg     <= ~en;
            disp_reg        <= disp_next;
            shadow_reg      <= shadow_next;
            pending_reg     <= pending_next;
            digit_en_reg    <= digit_en_next;
            digit_bcd_reg   <= digit_bcd_next;
            digit_blank_reg <= digit_blank_next;
            load_ack_reg    <= load_ack_next;
        end
    end

    // Slot sequencing: BLANK then SHOW per digit, idx wraps 0..3.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg + 1'b1;
        if (!en) begin
            state_next = ST_BLANK;
            idx_next   = 2'd0;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_next = ST_SHOW;
                        cnt_next   = '0;
                    end
                end
                default: begin
                    if (cnt_reg == ON_LAST) begin
                        state_next = ST_BLANK;
                        idx_next   = idx_reg + 2'd1;
                        cnt_next   = '0;
                    end
                end
            endcase
        end
    end

    assign frame_edge = en && (state_reg == ST_SHOW) && (idx_reg == 2'd3) && (cnt_reg == ON_LAST);

    // A held-off value lands either at the frame edge or, while dark, one cycle after capture.
    always_comb begin
        disp_next     = disp_reg;
        shadow_next   = shadow_reg;
        pending_next  = pending_reg;
        load_ack_next = 1'b0;
        if (bus.load) begin
            shadow_next  = bus.bcd_in;
            pending_next = 1'b1;
        end
        if (frame_edge) begin
            if (bus.load) begin
                disp_next     = bus.bcd_in;
                pending_next  = 1'b0;
                load_ack_next = 1'b1;
            end else if (pending_reg) begin
                disp_next     = shadow_reg;
                pending_next  = 1'b0;
                load_ack_next = 1'b1;
            end
        end else if (!en && restart_reg && pending_reg) begin
            disp_next     = shadow_reg;
            pending_next  = bus.load;
            load_ack_next = 1'b1;
        end
    end

    // Digit data is refreshed when a slot's BLANK begins, or on the first enabled edge after dark.
    assign load_digit = en && (((state_next == ST_BLANK) && (cnt_next == '0)) || restart_reg);

    always_comb begin
        digit_en_next    = 4'b0000;
        digit_bcd_next   = digit_bcd_reg;
        digit_blank_next = digit_blank_reg;
        if (en && (state_next == ST_SHOW) && (idx_next != 2'd3))
            digit_en_next = 4'b0001 << idx_next;
        if (!en) begin
            digit_blank_next = 1'b1;
        end else if (load_digit) begin
            case (idx_next)
                2'd0: begin
                    digit_bcd_next   = disp_next[3:0];
                    digit_blank_next = 1'b0;
                end
                2'd1: begin
                    digit_bcd_next   = disp_next[7:4];
                    digit_blank_next = lzs && (disp_next[11:4] == 8'h00);
                end
                2'd2: begin
                    digit_bcd_next   = disp_next[11:8];
                    digit_blank_next = lzs && (disp_next[11:8] == 4'h0);
                end
                default: begin
                    digit_bcd_next   = 4'h0;
                    digit_blank_next = 1'b1;
                end
            endcase
        end
    end

    assign bus.digit_en    = digit_en_reg;
    assign bus.digit_bcd   = digit_bcd_reg;
    assign bus.digit_blank = digit_blank_reg;
    assign bus.load_ack    = load_ack_reg;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios then random loads/enables,
// compared every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;
    localparam int ON    = 4;
    localparam int BL    = 2;
    localparam int SLOT  = ON + BL;
    localparam int FRAME = 4 * SLOT;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic en      = 1'b0;
    logic lzs     = 1'b0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(
        .ON_CYCLES    (ON),
        .BLANK_CYCLES (BL)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .lzs     (lzs),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int          n_pass  = 0;
    int          n_total = 0;
    int          pos;
    logic [11:0] disp_m;
    logic [11:0] shadow_m;
    bit          pending_m;
    bit          dark_m;
    bit          ack_m;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic logic [3:0] exp_bcd(input int s);
        logic [3:0] r;
        case (s)
            0:       r = disp_m[3:0];
            1:       r = disp_m[7:4];
            2:       r = disp_m[11:8];
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    function automatic logic exp_blank(input int s);
        logic r;
        case (s)
            0:       r = 1'b0;
            1:       r = lzs && (disp_m[11:8] == 4'h0) && (disp_m[7:4] == 4'h0);
            2:       r = lzs && (disp_m[11:8] == 4'h0);
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        pos       = 0;
        disp_m    = 12'h000;
        shadow_m  = 12'h000;
        pending_m = 1'b0;
        dark_m    = 1'b1;
        ack_m     = 1'b0;
    endtask

    // One clock: drive, advance model, then check all outputs 1 time unit after the edge.
    task automatic step(input bit l, input logic [11:0] b);
        int slot;
        bit in_show;
        logic [11:0] exp_en;
        bus.load   = l;
        bus.bcd_in = b;
        @(posedge clk);
        ack_m = 1'b0;
        if (en && pos == FRAME - 1) begin
            if (l) begin
                disp_m = b; pending_m = 1'b0; ack_m = 1'b1;
            end else if (pending_m) begin
                disp_m = shadow_m; pending_m = 1'b0; ack_m = 1'b1;
            end
        end else if (!en && dark_m && pending_m) begin
            disp_m = shadow_m; ack_m = 1'b1; pending_m = l;
            if (l) shadow_m = b;
        end else if (l) begin
            shadow_m = b; pending_m = 1'b1;
        end
        pos    = en ? (pos + 1) % FRAME : 0;
        dark_m = !en;
        #1;
        slot    = pos / SLOT;
        in_show = (pos % SLOT) >= BL;
        exp_en  = (in_show && slot != 3) ? 12'(1 << slot) : 12'h000;
        check("digit_en", {8'h00, bus.digit_en}, exp_en);
        check("load_ack", {11'h000, bus.load_ack}, {11'h000, ack_m});
        if (in_show) begin
            check("digit_bcd", {8'h00, bus.digit_bcd}, {8'h00, exp_bcd(slot)});
            check("digit_blank", {11'h000, bus.digit_blank}, {11'h000, exp_blank(slot)});
        end else if (!en) begin
            check("dark_blank", {11'h000, bus.digit_blank}, 12'h001);
        end
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'($urandom));
    endtask

    task automatic advance_to(input int target);
        for (int i = 0; i <= FRAME && pos != target; i++) step(1'b0, 12'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"},    {8'h00, bus.digit_en},     12'h000);
        check({tag, "_bcd"},   {8'h00, bus.digit_bcd},    12'h000);
        check({tag, "_blank"}, {11'h000, bus.digit_blank}, 12'h001);
        check({tag, "_ack"},   {11'h000, bus.load_ack},   12'h000);
    endtask

    initial begin
        int acks;
        int dark_left;
        logic [11:0] val;
        bus.load   = 1'b0;
        bus.bcd_in = 12'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #3;
        reset_n = 1'b1;
        en      = 1'b1;

        // Idle frame after reset: all digits show 0, idx3 slot dark.
        idle(FRAME);

        // Mid-frame load becomes visible only from the next frame.
        idle(7);
        step(1'b1, 12'h123);
        idle(2 * FRAME);

        // Leading-zero suppression on 007, then without suppression.
        en = 1'b0;
        idle(2);
        lzs = 1'b1;
        step(1'b1, 12'h007);
        idle(1);
        en = 1'b1;
        idle(FRAME);
        en = 1'b0;
        idle(1);
        lzs = 1'b0;
        idle(1);
        en = 1'b1;
        idle(FRAME);

        // Two loads in one frame: last wins, single acknowledge.
        advance_to(3);
        step(1'b1, 12'h111);
        idle(5);
        step(1'b1, 12'h222);
        acks = 0;
        for (int i = 0; i < FRAME; i++) begin
            step(1'b0, 12'($urandom));
            acks += int'(bus.load_ack);
            if (pos == 0) break;
        end
        check("single_ack", 12'(acks), 12'h001);
        idle(FRAME);

        // Load on the boundary cycle itself is applied on that edge.
        advance_to(FRAME - 1);
        step(1'b1, 12'h456);
        check("boundary_ack", {11'h000, bus.load_ack}, 12'h001);
        idle(FRAME);

        // Drop enable mid-SHOW with a pending value, then re-enable.
        advance_to(SLOT + BL + 1);
        step(1'b1, 12'h789);
        en = 1'b0;
        step(1'b0, 12'h000);
        check("dark_en_off", {8'h00, bus.digit_en}, 12'h000);
        step(1'b0, 12'h000);
        check("dark_apply_ack", {11'h000, bus.load_ack}, 12'h001);
        en = 1'b1;
        idle(2);
        check("restart_en", {8'h00, bus.digit_en}, 12'h001);
        idle(FRAME);

        // Asynchronous reset in the middle of a SHOW slot.
        advance_to(2 * SLOT + BL + 1);
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        model_reset();
        #2;
        reset_n = 1'b1;
        idle(FRAME);

        // Random loads, values and enable drops.
        dark_left = 0;
        for (int i = 0; i < 800; i++) begin
            if (en && $urandom_range(0, 99) < 3) begin
                en = 1'b0;
                dark_left = $urandom_range(1, 4);
            end else if (!en) begin
                if (dark_left == 0) begin
                    lzs = 1'($urandom);
                    en  = 1'b1;
                end else begin
                    dark_left--;
                end
            end
            val = ($urandom_range(0, 1) == 0) ? {8'h00, 4'($urandom)} : 12'($urandom);
            step($urandom_range(0, 9) == 0, val);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
